// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
//   mdu_op_e    - operation select as it arrives on the op port
//   mdu_state_e - sequencer states
//   MDU_WIDTH   - default datapath width, MDU_CNT_W its iteration counter width
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU into architectural HI/LO,
// plus MTHI/MTLO writes. One iteration per cycle, WIDTH iterations, then a
// sign-fix/writeback cycle.
//   clk, rst_n        - rising-edge clock, async active-low reset
//   A, B              - rs / rt operands, latched with op on an accepted start
//   op                - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start             - request, only looked at while idle
//   hi_we, lo_we      - MTHI / MTLO enables (idle only), data on wdata
//   busy              - operation in progress
//   done              - one-cycle pulse, HI/LO already hold the result
//   div_zero          - last accepted divide had B = 0 (held until next start)
//   hi, lo            - HI / LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    mdu_state_e         state, state_next;
    mdu_op_e            op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q, neg_r;

    logic               accept, signed_in, div_in, zero_div_in, div_q, last_iter;
    logic [WIDTH-1:0]   a_abs, b_abs, addend, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] acc_step, prod_fix;

    assign busy = (state != IDLE);

    always_comb begin
        accept      = (state == IDLE) && start;
        signed_in   = ~op[0];
        div_in      = op[1];
        zero_div_in = div_in && (B == '0);
        a_abs       = (signed_in && A[WIDTH-1]) ? -A : A;
        b_abs       = (signed_in && B[WIDTH-1]) ? -B : B;
        div_q       = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
        last_iter   = (cnt == CNT_W'(WIDTH - 1));
    end

    // Both algorithms share acc. Multiply: {partial product, multiplier},
    // add into the top half then shift right. Divide: {remainder, dividend},
    // shift left one bit and try subtracting the divisor; the quotient bit
    // enters at the bottom as the dividend bits leave the top.
    always_comb begin
        addend   = acc[0] ? b_q : '0;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        if (div_q) begin
            if (div_diff[WIDTH])
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = zero_div_in ? FIX : RUN;
            RUN:  if (last_iter) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MDU_MULT;
            cnt      <= '0;
            b_q      <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= (state == FIX);
            if (accept) begin
                op_q     <= mdu_op_e'(op);
                b_q      <= b_abs;
                acc      <= {{WIDTH{1'b0}}, a_abs};
                neg_q    <= signed_in && (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_r    <= signed_in && A[WIDTH-1];
                cnt      <= '0;
                div_zero <= zero_div_in;
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
            if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end else if (state == FIX && !div_zero) begin
                // div_zero is only ever set by the start that led here, so
                // it doubles as the "skip writeback" marker for B = 0.
                if (div_q) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven and hand-sequenced checks of mult_div_unit
// with a scoreboard of expected HI/LO/div_zero/latency popped on each done.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_i = '0, b_i = '0, wdata = '0;
    logic [1:0]  op_i = '0;
    logic        start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .A(a_i), .B(b_i), .op(op_i), .start(start),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          start_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_hi"}, hi, mon_e.hi);
                chk({mon_e.name, "_lo"}, lo, mon_e.lo);
                chk({mon_e.name, "_div_zero"}, 32'(div_zero), 32'(mon_e.dz));
                chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
            end
        end
    end

    logic [31:0] mhi = '0, mlo = '0;

    // Called at a negedge; returns at the negedge of the done cycle so the
    // next call issues its start in that done cycle.
    // mode 0: plain; 1: retry start + MTHI/MTLO in cycle 5; 2: MTHI with start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int mode, input string name);
        exp_t        e, junk;
        int          n, busy_cnt, lat;
        bit          got, stable;
        logic [31:0] ph, pl;
        lat = (o[1] && b == 32'd0) ? 2 : WIDTH + 2;
        ph = mhi;
        pl = mlo;
        op_i = o; a_i = a; b_i = b; start = 1'b1;
        if (mode == 2) begin
            hi_we = 1'b1;
            wdata = 32'hCAFEF00D;
            ph = 32'hCAFEF00D;
        end
        e.hi = ehi; e.lo = elo; e.dz = edz; e.start_cyc = cyc; e.lat = lat; e.name = name;
        sb.push_back(e);
        mhi = ehi;
        mlo = elo;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        n = 0; busy_cnt = 0; got = 1'b0; stable = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n == 5) begin
                start = 1'b1; op_i = 2'b11; a_i = 32'h55; b_i = 32'h0;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
            end
            if (mode == 1 && n == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            if (done) got = 1'b1;
            else begin
                if (busy) busy_cnt++;
                if (hi !== ph || lo !== pl) stable = 1'b0;
            end
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
        chk({name, "_hilo_stable"}, 32'(stable), 32'd1);
        chk({name, "_idle_at_done"}, 32'(busy), 32'd0);
        if (!got && sb.size() > 0) junk = sb.pop_back();
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ch, input logic [31:0] cl,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint          p, r;
        longint unsigned pu;
        edz = 1'b0; eh = ch; el = cl;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                eh = p[63:32]; el = p[31:0];
            end
            2'b01: begin
                pu = longint'(a) * longint'(b);
                eh = pu[63:32]; el = pu[31:0];
            end
            2'b10: begin
                if (b == 32'd0) edz = 1'b1;
                else begin
                    p = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    el = p[31:0]; eh = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) edz = 1'b1;
                else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, eh, el;
        logic        edz;
        bit          saw;

        #1000000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, eh, el;
        logic        edz;
        bit          saw;

        tbl[0]  = '{2'b11, 32'd100,       32'd0,        32'h11,       32'h22,       1'b1, "divu_zero"};
        tbl[1]  = '{2'b11, 32'd100,       32'd7,        32'd2,        32'd14,       1'b0, "divu_100_7"};
        tbl[2]  = '{2'b01, 32'hFFFFFFFF,  32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, "multu_max_2"};
        tbl[3]  = '{2'b00, 32'hFFFFFFFD,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult_m3_5"};
        tbl[4]  = '{2'b10, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2"};
        tbl[5]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_overflow"};
        tbl[6]  = '{2'b00, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_min_min"};
        tbl[7]  = '{2'b10, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7_m2"};
        tbl[8]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max_max"};
        tbl[9]  = '{2'b11, 32'hFFFFFFFF,  32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, "divu_max_1"};
        tbl[10] = '{2'b10, 32'hFFFFFFF8,  32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, "div_m8_m3"};
        tbl[11] = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mult_m1_m1"};
        tbl[12] = '{2'b11, 32'd5,         32'd10,       32'd5,        32'd0,        1'b0, "divu_5_10"};
        tbl[13] = '{2'b10, 32'd0,         32'd5,        32'd0,        32'd0,        1'b0, "div_0_5"};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst_n = 1'b1;

        // MTHI / MTLO preload
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);
        mhi = 32'h11;
        mlo = 32'h22;

        // Table: rows run back-to-back, each start issued in the previous done cycle
        for (int i = 0; i < 14; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, 0, tbl[i].name);

        // Start and MTHI/MTLO while busy are both ignored
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1, "busy_ignore");

        // MTHI together with start: write lands, result overwrites it later
        run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2, "mthi_with_start");

        // div_zero holds after done and clears on the next start
        run_op(2'b11, 32'd5, 32'd0, 32'd0, 32'd42, 1'b1, 0, "divu_zero2");
        repeat (3) @(negedge clk);
        chk("div_zero_sticky", 32'(div_zero), 32'd1);
        run_op(2'b01, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 0, "after_zero");

        // Random ops against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            model(ro, ra, rb, mhi, mlo, eh, el, edz);
            run_op(ro, ra, rb, eh, el, edz, 0, "rand");
        end

        // Reset in cycle 10 of a DIV aborts with no done afterwards
        op_i = 2'b10; a_i = 32'hFFFFFC18; b_i = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_div_zero", 32'(div_zero), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        sb.delete();
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("midrst_no_done", 32'(saw), 32'd0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, "post_reset");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS datapath, placed beside the ALU in the execute stage.
- Takes the same rs/rt operands from the register file that feed the ALU's A/B inputs.
- Implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers. Also supports MTHI/MTLO writes.
- Control stalls the processor on busy and consumes HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand rs (multiplicand / dividend).
- B  input  WIDTH  operand rt (multiplier / divisor).
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- start  input  1  request; sampled only when busy=0.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_zero  output  1  sticky-until-next-start flag: last divide had B=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n).
  - While rst_n=0: state=IDLE; busy, done, div_zero=0; hi, lo=0; internal counters and accumulators cleared.
  - Reset mid-operation aborts immediately. No done pulse follows.
- States:
  - IDLE: accepts start.
  - RUN: one iteration per cycle, counter 0..WIDTH-1.
  - FIX: sign correction and HI/LO writeback.
- Timing: start sampled high at edge 0 in IDLE; operands and op are latched at that edge.
- Normal path: busy=1 for cycles 1..WIDTH+1. At edge WIDTH+1, HI/LO are written and state returns to IDLE. done=1 in cycle WIDTH+2 only (cycle 34 for WIDTH=32). busy = (state != IDLE), decoded from registered state.
- Signed ops: the absolute values of A and B are latched, along with the result signs.
  - Product sign = sign(A) xor sign(B).
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
  - Negation is applied in FIX.
- Multiply: shift-add over WIDTH cycles into a 2*WIDTH accumulator. HI = upper half, LO = lower half.
- Divide: restoring, one quotient bit per cycle. LO = quotient (truncated toward zero). HI = remainder.
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0. No flag.
- Divide by zero (op DIV/DIVU with B=0 at start):
  - RUN is skipped: edge 0 goes to FIX, edge 1 goes to IDLE.
  - busy=1 in cycle 1 only; done=1 in cycle 2.
  - HI/LO unchanged; div_zero=1.
- div_zero clears on the next accepted start.
- start while busy=1 is ignored. It is not queued.
- hi_we/lo_we:
  - Honoured only when busy=0; hi/lo update at the clock edge. Ignored while busy.
  - Same-cycle start + hi_we in IDLE: the write takes effect, start is accepted, and the operation result later overwrites HI.
  - In the done cycle (IDLE), hi_we/lo_we and a new start are legal.
- hi and lo are registered outputs. They are stable throughout RUN and show the previous values until the done cycle.

Decomposition:
- mdu_pkg:
  - op enum: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU.
  - state enum: IDLE, RUN, FIX.
  - localparam for counter width, $clog2(WIDTH).
- Single module. The datapath is small enough that no sub-module is warranted.

Test Plan:
- MULTU A=0xFFFFFFFF B=2, start pulse -> busy cycles 1–33, done cycle 34, HI=0x00000001, LO=0xFFFFFFFE.
- MULT A=-3 (0xFFFFFFFD) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100 B=0, with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> busy cycle 1 only, done cycle 2, div_zero=1, HI/LO unchanged. Then DIVU 100/7 -> div_zero=0, LO=14, HI=2.
- Second start asserted at cycle 5 with different operands -> ignored; first result delivered at cycle 34. hi_we during busy -> HI not modified.
- rst_n low at cycle 10 of a DIV -> busy, hi, lo, div_zero=0 immediately. No done pulse afterwards. Next start completes normally.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Back-to-back start in the done cycle is accepted, and its done arrives 34 cycles later.
